// File: rtl/rr_encoder_16_4.sv
// Registered round-robin N-to-log2(N) encoder with a valid/ready output stage.
// One grant per transfer; the search starts just past the last accepted index.
module rr_encoder_16_4 #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic [W-1:0] enc_out,
    output logic [N-1:0] grant,
    output logic         enc_valid,
    output logic         multi
);

    logic [W-1:0] ptr;
    logic [W-1:0] ptr_next;
    logic [W-1:0] start;
    logic [W-1:0] first;
    logic [W-1:0] pick;
    logic [N-1:0] rot;
    logic         hs;
    logic         load;
    logic         any_req;
    logic         multi_next;

    assign hs       = enc_valid & out_ready;
    assign load     = ~enc_valid | out_ready;
    assign ptr_next = enc_out + W'(1);

    // A grant accepted this edge moves the search origin immediately.
    assign start    = hs ? ptr_next : ptr;

    // Rotate req so that bit 0 of rot is the requester at the search origin.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign rot[gi] = req[start + W'(gi)];
    end

    always_comb begin
        first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) first = W'(i);
        end
    end

    assign pick       = start + first;
    assign any_req    = |req;
    assign multi_next = |(req & (req - N'(1)));

    always_ff @(posedge clk) begin
        if (clr) begin
            enc_out   <= '0;
            grant     <= '0;
            enc_valid <= 1'b0;
            multi     <= 1'b0;
            ptr       <= '0;
        end else begin
            if (hs) ptr <= ptr_next;
            if (load) begin
                if (any_req) begin
                    enc_out   <= pick;
                    grant     <= N'(1) << pick;
                    enc_valid <= 1'b1;
                    multi     <= multi_next;
                end else begin
                    grant     <= '0;
                    enc_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_encoder_16_4.sv
// Bench for rr_encoder_16_4: directed scenarios plus randomized traffic
// compared against a search-based behavioural model of the arbiter.
module tb_rr_encoder_16_4;

    localparam int N = 16;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic [N-1:0] req = '0;
    logic         out_ready = 1'b0;
    logic [W-1:0] enc_out;
    logic [N-1:0] grant;
    logic         enc_valid;
    logic         multi;

    int checks = 0;
    int errors = 0;

    // Reference state: held grant index, valid, multi flag and search origin.
    int m_idx   = 0;
    bit m_valid = 0;
    bit m_multi = 0;
    int m_ptr   = 0;

    rr_encoder_16_4 #(.N(N), .W(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .req       (req),
        .out_ready (out_ready),
        .enc_out   (enc_out),
        .grant     (grant),
        .enc_valid (enc_valid),
        .multi     (multi)
    );

    always #5 clk = ~clk;

    // Advance one clock: update the model from the inputs seen at the edge,
    // then settle so outputs can be sampled away from the edge.
    task automatic tick();
        bit hs;
        bit ld;
        int cnt;
        @(posedge clk);
        if (clr) begin
            m_idx = 0; m_valid = 0; m_multi = 0; m_ptr = 0;
        end else begin
            hs = m_valid && out_ready;
            ld = !m_valid || out_ready;
            if (hs) m_ptr = (m_idx + 1) % N;
            if (ld) begin
                if (req == '0) begin
                    m_valid = 0;
                end else begin
                    cnt = 0;
                    for (int b = 0; b < N; b++) cnt += req[b];
                    for (int j = N - 1; j >= 0; j--)
                        if (req[(m_ptr + j) % N]) m_idx = (m_ptr + j) % N;
                    m_valid = 1;
                    m_multi = (cnt > 1);
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        clr = 1; req = 16'hFFFF; out_ready = 1;
        tick(); tick();
        checks++; if (enc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", enc_valid); end
        checks++; if (grant !== 16'h0) begin errors++; $display("FAIL reset_grant got %h want 0000", grant); end
        checks++; if (enc_out !== 4'd0) begin errors++; $display("FAIL reset_enc got %0d want 0", enc_out); end
        checks++; if (multi !== 1'b0) begin errors++; $display("FAIL reset_multi got %0b want 0", multi); end
        clr = 0; req = '0;
        tick();
    endtask

    task automatic test_single();
        req = 16'h0020; out_ready = 1;
        tick();
        checks++; if (enc_out !== 4'd5) begin errors++; $display("FAIL single_enc got %0d want 5", enc_out); end
        checks++; if (grant !== 16'h0020) begin errors++; $display("FAIL single_grant got %h want 0020", grant); end
        checks++; if (enc_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", enc_valid); end
        checks++; if (multi !== 1'b0) begin errors++; $display("FAIL single_multi got %0b want 0", multi); end
        req = '0;
        tick();
        checks++; if (enc_valid !== 1'b0 || grant !== 16'h0) begin errors++; $display("FAIL single_drain got v=%0b g=%h want v=0 g=0000", enc_valid, grant); end
    endtask

    task automatic test_round_robin();
        clr = 1; tick(); clr = 0;
        req = 16'hFFFF; out_ready = 1;
        for (int i = 0; i < 18; i++) begin
            tick();
            checks++;
            if (enc_out !== W'(i % N) || grant !== (16'h1 << (i % N)) || enc_valid !== 1'b1 || multi !== 1'b1) begin
                errors++;
                $display("FAIL rr_step%0d got enc=%0d g=%h v=%0b m=%0b want enc=%0d v=1 m=1", i, enc_out, grant, enc_valid, multi, i % N);
            end
        end
        req = '0; tick();
    endtask

    task automatic test_stall();
        clr = 1; tick(); clr = 0;
        req = 16'h0101; out_ready = 0;
        tick();
        req = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (enc_out !== 4'd0 || enc_valid !== 1'b1 || grant !== 16'h0001 || multi !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d got enc=%0d g=%h v=%0b m=%0b want enc=0 g=0001 v=1 m=1", i, enc_out, grant, enc_valid, multi);
            end
            tick();
        end
        out_ready = 1;
        tick();
        checks++; if (enc_out !== 4'd8 || multi !== 1'b0) begin errors++; $display("FAIL stall_next got enc=%0d m=%0b want enc=8 m=0", enc_out, multi); end
        tick();
        checks++; if (enc_out !== 4'd8 || enc_valid !== 1'b1) begin errors++; $display("FAIL stall_again got enc=%0d v=%0b want enc=8 v=1", enc_out, enc_valid); end
        req = '0; tick();
    endtask

    task automatic test_wrap();
        clr = 1; tick(); clr = 0;
        req = 16'h4000; out_ready = 1;
        tick();
        checks++; if (enc_out !== 4'd14) begin errors++; $display("FAIL wrap_setup got %0d want 14", enc_out); end
        req = 16'h0003;
        tick();
        checks++; if (enc_out !== 4'd0 || grant !== 16'h0001) begin errors++; $display("FAIL wrap_skip got enc=%0d g=%h want enc=0 g=0001", enc_out, grant); end
        tick();
        checks++; if (enc_out !== 4'd1 || grant !== 16'h0002) begin errors++; $display("FAIL wrap_next got enc=%0d g=%h want enc=1 g=0002", enc_out, grant); end
        req = '0; tick();
    endtask

    task automatic test_midreset();
        clr = 1; tick(); clr = 0;
        req = 16'h0200; out_ready = 0;
        tick();
        checks++; if (enc_out !== 4'd9 || enc_valid !== 1'b1) begin errors++; $display("FAIL mid_pending got enc=%0d v=%0b want enc=9 v=1", enc_out, enc_valid); end
        clr = 1;
        tick();
        checks++; if (enc_valid !== 1'b0 || grant !== 16'h0) begin errors++; $display("FAIL mid_clr got v=%0b g=%h want v=0 g=0000", enc_valid, grant); end
        clr = 0; req = 16'h0600; out_ready = 1;
        tick();
        checks++; if (enc_out !== 4'd9 || multi !== 1'b1) begin errors++; $display("FAIL mid_after got enc=%0d m=%0b want enc=9 m=1", enc_out, multi); end
        req = '0; tick();
    endtask

    task automatic test_random();
        logic [N-1:0] exp_g;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0: req = '0;
                1: req = N'(1) << $urandom_range(0, N - 1);
                2: req = N'($urandom) & N'($urandom);
                default: req = N'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            tick();
            exp_g = m_valid ? (N'(1) << m_idx) : '0;
            checks++;
            if (enc_valid !== m_valid || grant !== exp_g || enc_out !== W'(m_idx) || multi !== m_multi) begin
                errors++;
                $display("FAIL rand_c%0d got enc=%0d g=%h v=%0b m=%0b want enc=%0d g=%h v=%0b m=%0b",
                         c, enc_out, grant, enc_valid, multi, m_idx, exp_g, m_valid, m_multi);
            end
        end
        clr = 0; req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_wrap();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
